// File: rtl/r_type_pipe_exec_if.sv
// r_type_pipe_exec_if: issue/result handshake bundle for the r_type_pipe_exec unit
// master: decoder/commit side (drives instruction fields and out_ready)
// slave : execution unit (drives in_ready and the registered result/flags)
interface r_type_pipe_exec_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);
  logic in_valid;
  logic in_ready;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;
  logic [AW-1:0] rd;
  logic [3:0] alu_op;
  logic out_valid;
  logic out_ready;
  logic [AW-1:0] out_rd;
  logic [XLEN-1:0] out_result;
  logic out_zero;
  logic out_carry;
  logic out_overflow;
  modport master (
    output in_valid, rs1, rs2, rd, alu_op, out_ready,
    input in_ready, out_valid, out_rd, out_result, out_zero, out_carry, out_overflow
  );
  modport slave (
    input in_valid, rs1, rs2, rd, alu_op, out_ready,
    output in_ready, out_valid, out_rd, out_result, out_zero, out_carry, out_overflow
  );
endinterface

// File: rtl/r_type_pipe_exec.sv
// r_type_pipe_exec: two-stage R-type execution unit (regfile, bypass, ALU, writeback)
// Ports: clk, rst (sync, active-high), bus (r_type_pipe_exec_if.slave):
//   in_valid/in_ready + rs1/rs2/rd/alu_op in; out_valid/out_ready + out_rd/out_result/flags out.
// Optional: define ZERO_REG_EN to make register 0 read as zero and ignore writes to it.
module r_type_pipe_exec #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter logic [XLEN-1:0] RESET_VAL = XLEN'(21)
) (
  input logic clk,
  input logic rst,
  r_type_pipe_exec_if.slave bus
);
  localparam int AW = $clog2(NREG);
  logic [XLEN-1:0] regs [NREG];
  logic s1_valid;
  logic [AW-1:0] s1_rs1, s1_rs2, s1_rd;
  logic [3:0] s1_op;
  logic s2_free, adv, ready, acc;
  logic [XLEN-1:0] a, b, res;
  logic [XLEN:0] sum, diff;
  logic carry, ovf;
  // Address is a real, writable register (out-of-range and, optionally, r0 are not).
  function automatic logic live(input logic [AW-1:0] r);
`ifdef ZERO_REG_EN
    live = (32'(r) < 32'(NREG)) && (r != '0);
`else
    live = 32'(r) < 32'(NREG);
`endif
  endfunction
  assign s2_free = !bus.out_valid || bus.out_ready;
  assign adv = s1_valid && s2_free;
  assign ready = !s1_valid || s2_free;
  assign acc = bus.in_valid && ready;
  assign bus.in_ready = ready;
  // Bypass from S2 even when it is not handing off this cycle: its result is the newest value.
  always_comb begin
    a = !live(s1_rs1) ? '0 : (bus.out_valid && bus.out_rd == s1_rs1) ? bus.out_result : regs[s1_rs1];
    b = !live(s1_rs2) ? '0 : (bus.out_valid && bus.out_rd == s1_rs2) ? bus.out_result : regs[s1_rs2];
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res = s1_op == 4'b0000 ? a & b :
          s1_op == 4'b0001 ? a | b :
          s1_op == 4'b0010 ? sum[XLEN-1:0] :
          s1_op == 4'b0110 ? diff[XLEN-1:0] :
          s1_op == 4'b0111 ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} :
          s1_op == 4'b0011 ? {{(XLEN-1){1'b0}}, a < b} :
          s1_op == 4'b1100 ? ~(a | b) : '0;
    carry = s1_op == 4'b0010 ? sum[XLEN] : s1_op == 4'b0110 ? !diff[XLEN] : 1'b0;
    ovf = s1_op == 4'b0010 ? (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]) :
          s1_op == 4'b0110 ? (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_rd <= '0;
      bus.out_result <= '0;
      bus.out_zero <= 1'b0;
      bus.out_carry <= 1'b0;
      bus.out_overflow <= 1'b0;
    end else begin
      if (acc) begin
        s1_valid <= 1'b1;
        s1_rs1 <= bus.rs1;
        s1_rs2 <= bus.rs2;
        s1_rd <= bus.rd;
        s1_op <= bus.alu_op;
      end else if (adv) s1_valid <= 1'b0;
      if (adv) begin
        bus.out_valid <= 1'b1;
        bus.out_rd <= s1_rd;
        bus.out_result <= res;
        bus.out_zero <= res == '0;
        bus.out_carry <= carry;
        bus.out_overflow <= ovf;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NREG; i++) regs[i] <= RESET_VAL;
    else if (bus.out_valid && bus.out_ready && live(bus.out_rd)) regs[bus.out_rd] <= bus.out_result;
  end
endmodule
